// File: rtl/reg_bank_pkg.sv
// Shared definitions for the N-channel register bank: defaults, read-select
// width helper and the write-enable population classifier.
package reg_bank_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_CHANNELS   = 2;
    localparam int unsigned MAX_CHANNELS   = 64;

    typedef enum logic [1:0] {
        EN_ZERO,
        EN_ONE,
        EN_MANY
    } en_class_e;

    function automatic int unsigned sel_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Clearing the lowest set bit leaves zero only for a one-hot vector.
    function automatic en_class_e classify_en(input logic [MAX_CHANNELS-1:0] en);
        if (en == '0)
            return EN_ZERO;
        if ((en & (en - 1'b1)) == '0)
            return EN_ONE;
        return EN_MANY;
    endfunction

endpackage

// File: rtl/reg_bank_chan.sv
// One channel of the register bank: data, valid and sticky overwrite flag.
// Stores an even-parity bit when REG_BANK_PARITY_EN is defined.
module reg_bank_chan
    import reg_bank_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  consume,
    input  logic [DATA_WIDTH-1:0] din,
`ifdef REG_BANK_PARITY_EN
    input  logic                  par_inject,
    output logic                  par_err,
`endif
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  valid,
    output logic                  ovf
);

    // A load wins over a same-cycle consume: the old value is read out while
    // the new one lands, so valid stays set and no overwrite is recorded.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout  <= '0;
            valid <= 1'b0;
            ovf   <= 1'b0;
        end else if (load) begin
            dout  <= din;
            valid <= 1'b1;
            if (valid && !consume)
                ovf <= 1'b1;
        end else if (consume) begin
            valid <= 1'b0;
        end
    end

`ifdef REG_BANK_PARITY_EN
    logic par_q;

    always_ff @(posedge clk) begin
        if (!rst_n)
            par_q <= 1'b0;
        else if (load)
            par_q <= (^din) ^ par_inject;
    end

    assign par_err = par_q ^ (^dout);
`endif

endmodule

// File: rtl/reg_bank_nch.sv
// N-channel data register bank with exclusive/parallel write mode, valid and
// overwrite tracking, and a registered consume-on-read port.
// Optional parity storage and check: define REG_BANK_PARITY_EN.
module reg_bank_nch
    import reg_bank_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned CHANNELS   = DEF_CHANNELS,
    parameter bit          EXCLUSIVE  = 1'b1,
    localparam int unsigned SEL_W     = sel_width(CHANNELS)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [CHANNELS-1:0]            wr_en,
    input  logic [CHANNELS*DATA_WIDTH-1:0] wr_data,
    output logic [CHANNELS*DATA_WIDTH-1:0] data_out,
    output logic [CHANNELS-1:0]            valid,
    output logic [CHANNELS-1:0]            ovf,
    output logic                           wr_err,
    input  logic                           rd_en,
    input  logic [SEL_W-1:0]               rd_sel,
`ifdef REG_BANK_PARITY_EN
    input  logic                           par_inject,
    output logic                           rd_par_err,
`endif
    output logic [DATA_WIDTH-1:0]          rd_data,
    output logic                           rd_valid
);

    en_class_e             en_class;
    logic [CHANNELS-1:0]   load;
    logic [CHANNELS-1:0]   consume;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sel_valid;
    logic                  rd_hit;
`ifdef REG_BANK_PARITY_EN
    logic [CHANNELS-1:0]   chan_par_err;
    logic                  sel_par_err;
`endif

    assign en_class = classify_en(MAX_CHANNELS'(wr_en));
    assign load     = (!EXCLUSIVE || en_class == EN_ONE) ? wr_en : '0;

    // An out-of-range rd_sel matches no channel and therefore never hits.
    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        consume   = '0;
`ifdef REG_BANK_PARITY_EN
        sel_par_err = 1'b0;
`endif
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (rd_sel == SEL_W'(i)) begin
                sel_data   = data_out[i*DATA_WIDTH +: DATA_WIDTH];
                sel_valid  = valid[i];
                consume[i] = rd_en & valid[i];
`ifdef REG_BANK_PARITY_EN
                sel_par_err = chan_par_err[i];
`endif
            end
        end
    end

    assign rd_hit = rd_en & sel_valid;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        reg_bank_chan #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .load       (load[g]),
            .consume    (consume[g]),
            .din        (wr_data[g*DATA_WIDTH +: DATA_WIDTH]),
`ifdef REG_BANK_PARITY_EN
            .par_inject (par_inject),
            .par_err    (chan_par_err[g]),
`endif
            .dout       (data_out[g*DATA_WIDTH +: DATA_WIDTH]),
            .valid      (valid[g]),
            .ovf        (ovf[g])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
            wr_err   <= 1'b0;
`ifdef REG_BANK_PARITY_EN
            rd_par_err <= 1'b0;
`endif
        end else begin
            rd_valid <= rd_hit;
            wr_err   <= EXCLUSIVE && (en_class == EN_MANY);
            if (rd_hit)
                rd_data <= sel_data;
`ifdef REG_BANK_PARITY_EN
            rd_par_err <= rd_hit & sel_par_err;
`endif
        end
    end

endmodule

// File: tb/tb_reg_bank_nch.sv
// Bench for reg_bank_nch: three configurations driven in lockstep against a
// behavioural model; parity checks are included when REG_BANK_PARITY_EN is set.
module tb_reg_bank_nch;

    localparam int unsigned NCH  [3] = '{2, 2, 5};
    localparam int unsigned DW   [3] = '{8, 8, 16};
    localparam int unsigned EXC  [3] = '{1, 0, 1};
    localparam int unsigned SELW [3] = '{1, 1, 3};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rd_en = 1'b0;
    logic pinj = 1'b0;

    logic [1:0]  we0 = '0, we1 = '0;
    logic [15:0] wd0 = '0, wd1 = '0;
    logic        rs0 = 1'b0, rs1 = 1'b0;
    logic [15:0] dout0, dout1;
    logic [1:0]  valid0, valid1, ovf0, ovf1;
    logic        werr0, werr1, rdv0, rdv1, perr0, perr1;
    logic [7:0]  rdd0, rdd1;

    logic [4:0]  we2 = '0;
    logic [79:0] wd2 = '0;
    logic [2:0]  rs2 = '0;
    logic [79:0] dout2;
    logic [4:0]  valid2, ovf2;
    logic        werr2, rdv2, perr2;
    logic [15:0] rdd2;

    int tests = 0;
    int fails = 0;

    // Behavioural model and captured DUT outputs, zero-extended to the widest config.
    logic [15:0] m_dout [3][5];
    logic        m_par  [3][5];
    logic [4:0]  m_valid [3], m_ovf [3];
    logic        m_werr [3], m_rdv [3], m_perr [3];
    logic [15:0] m_rdd [3];

    logic [15:0] a_dout [3][5];
    logic [4:0]  a_valid [3], a_ovf [3];
    logic        a_werr [3], a_rdv [3], a_perr [3];
    logic [15:0] a_rdd [3];

    logic [4:0][15:0] wdv;

    always #5 clk = ~clk;

    reg_bank_nch u0 (
        .clk(clk), .rst_n(rst_n), .wr_en(we0), .wr_data(wd0), .data_out(dout0),
        .valid(valid0), .ovf(ovf0), .wr_err(werr0), .rd_en(rd_en), .rd_sel(rs0),
`ifdef REG_BANK_PARITY_EN
        .par_inject(pinj), .rd_par_err(perr0),
`endif
        .rd_data(rdd0), .rd_valid(rdv0)
    );

    reg_bank_nch #(.DATA_WIDTH(8), .CHANNELS(2), .EXCLUSIVE(1'b0)) u1 (
        .clk(clk), .rst_n(rst_n), .wr_en(we1), .wr_data(wd1), .data_out(dout1),
        .valid(valid1), .ovf(ovf1), .wr_err(werr1), .rd_en(rd_en), .rd_sel(rs1),
`ifdef REG_BANK_PARITY_EN
        .par_inject(pinj), .rd_par_err(perr1),
`endif
        .rd_data(rdd1), .rd_valid(rdv1)
    );

    reg_bank_nch #(.DATA_WIDTH(16), .CHANNELS(5), .EXCLUSIVE(1'b1)) u2 (
        .clk(clk), .rst_n(rst_n), .wr_en(we2), .wr_data(wd2), .data_out(dout2),
        .valid(valid2), .ovf(ovf2), .wr_err(werr2), .rd_en(rd_en), .rd_sel(rs2),
`ifdef REG_BANK_PARITY_EN
        .par_inject(pinj), .rd_par_err(perr2),
`endif
        .rd_data(rdd2), .rd_valid(rdv2)
    );

`ifndef REG_BANK_PARITY_EN
    assign perr0 = 1'b0;
    assign perr1 = 1'b0;
    assign perr2 = 1'b0;
`endif

    task automatic snap();
        for (int j = 0; j < 5; j++) begin
            a_dout[0][j] = (j < 2) ? {8'h00, dout0[j*8 +: 8]} : 16'h0000;
            a_dout[1][j] = (j < 2) ? {8'h00, dout1[j*8 +: 8]} : 16'h0000;
            a_dout[2][j] = dout2[j*16 +: 16];
        end
        a_valid[0] = {3'b000, valid0}; a_valid[1] = {3'b000, valid1}; a_valid[2] = valid2;
        a_ovf[0]   = {3'b000, ovf0};   a_ovf[1]   = {3'b000, ovf1};   a_ovf[2]   = ovf2;
        a_werr[0]  = werr0; a_werr[1] = werr1; a_werr[2] = werr2;
        a_rdv[0]   = rdv0;  a_rdv[1]  = rdv1;  a_rdv[2]  = rdv2;
        a_perr[0]  = perr0; a_perr[1] = perr1; a_perr[2] = perr2;
        a_rdd[0]   = {8'h00, rdd0}; a_rdd[1] = {8'h00, rdd1}; a_rdd[2] = rdd2;
    endtask

    // Drive one cycle on all three instances, advance the model, sample #1 after the edge.
    task automatic step(input logic r, input logic [4:0] we, input logic [4:0][15:0] wd,
                        input logic ren, input logic [2:0] rs, input logic pi);
        logic [4:0]  wek;
        logic [2:0]  rsk;
        logic [15:0] msk;
        int unsigned cnt;
        bit          acc, hit;
        @(negedge clk);
        rst_n = r;
        we0 = we[1:0]; we1 = we[1:0]; we2 = we;
        wd0 = {wd[1][7:0], wd[0][7:0]}; wd1 = wd0; wd2 = wd;
        rd_en = ren; rs0 = rs[0]; rs1 = rs[0]; rs2 = rs;
        pinj = pi;
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (!r) begin
                m_valid[k] = '0; m_ovf[k] = '0; m_werr[k] = 1'b0;
                m_rdv[k] = 1'b0; m_perr[k] = 1'b0; m_rdd[k] = '0;
                for (int j = 0; j < 5; j++) begin
                    m_dout[k][j] = '0;
                    m_par[k][j]  = 1'b0;
                end
            end else begin
                wek = (NCH[k] == 2) ? (we & 5'b00011) : we;
                rsk = (SELW[k] == 1) ? {2'b00, rs[0]} : rs;
                msk = (DW[k] == 8) ? 16'h00FF : 16'hFFFF;
                cnt = $countones(wek);
                acc = (EXC[k] == 0) || (cnt == 1);
                hit = ren && (int'(rsk) < int'(NCH[k])) && m_valid[k][rsk];
                m_werr[k] = (EXC[k] != 0) && (cnt > 1);
                m_rdv[k]  = hit;
                m_perr[k] = 1'b0;
                if (hit) begin
                    m_rdd[k]  = m_dout[k][rsk];
                    m_perr[k] = m_par[k][rsk] != (^m_dout[k][rsk]);
                    m_valid[k][rsk] = 1'b0;
                end
                if (acc) begin
                    for (int j = 0; j < 5; j++) begin
                        if (wek[j]) begin
                            if (m_valid[k][j]) m_ovf[k][j] = 1'b1;
                            m_dout[k][j]  = wd[j] & msk;
                            m_par[k][j]   = (^(wd[j] & msk)) ^ pi;
                            m_valid[k][j] = 1'b1;
                        end
                    end
                end
            end
        end
        #1;
        snap();
    endtask

    task automatic test_reset();
        wdv = '0; wdv[0] = 16'h1234; wdv[1] = 16'h5678;
        step(1'b0, 5'b00000, wdv, 1'b0, 3'd0, 1'b0);
        step(1'b1, 5'b00001, wdv, 1'b0, 3'd0, 1'b0);
        step(1'b1, 5'b00010, wdv, 1'b0, 3'd0, 1'b0);
        step(1'b0, 5'b00011, wdv, 1'b1, 3'd1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tests++;
            if (a_valid[k] !== 5'b0 || a_ovf[k] !== 5'b0 || a_werr[k] !== 1'b0 ||
                a_rdv[k] !== 1'b0 || a_rdd[k] !== 16'h0 || a_dout[k][0] !== 16'h0 ||
                a_dout[k][1] !== 16'h0) begin
                fails++;
                $display("FAIL reset_inst%0d: valid=%b ovf=%b werr=%b rdv=%b rdd=%h d0=%h d1=%h, required all zero",
                         k, a_valid[k], a_ovf[k], a_werr[k], a_rdv[k], a_rdd[k], a_dout[k][0], a_dout[k][1]);
            end
        end
    endtask

    task automatic test_write_read();
        wdv = '0; wdv[0] = 16'h00A5;
        step(1'b1, 5'b00001, wdv, 1'b0, 3'd0, 1'b0);
        tests++;
        if (dout0[7:0] !== 8'hA5 || valid0 !== 2'b01 || ovf0 !== 2'b00) begin
            fails++;
            $display("FAIL write_ch0: dout=%h valid=%b ovf=%b, required a5 01 00", dout0[7:0], valid0, ovf0);
        end
        step(1'b1, 5'b00000, wdv, 1'b1, 3'd0, 1'b0);
        tests++;
        if (rdd0 !== 8'hA5 || rdv0 !== 1'b1 || valid0 !== 2'b00) begin
            fails++;
            $display("FAIL read_ch0: rdd=%h rdv=%b valid=%b, required a5 1 00", rdd0, rdv0, valid0);
        end
    endtask

    task automatic test_conflict();
        wdv = '0; wdv[0] = 16'h0011; wdv[1] = 16'h0022;
        step(1'b1, 5'b00011, wdv, 1'b0, 3'd0, 1'b0);
        tests++;
        if (werr0 !== 1'b1 || dout0 !== 16'h00A5 || valid0 !== 2'b00) begin
            fails++;
            $display("FAIL conflict_excl: werr=%b dout=%h valid=%b, required 1 00a5 00", werr0, dout0, valid0);
        end
        tests++;
        if (werr1 !== 1'b0 || dout1 !== 16'h2211 || valid1 !== 2'b11) begin
            fails++;
            $display("FAIL conflict_par: werr=%b dout=%h valid=%b, required 0 2211 11", werr1, dout1, valid1);
        end
        step(1'b1, 5'b00000, wdv, 1'b0, 3'd0, 1'b0);
        tests++;
        if (werr0 !== 1'b0) begin
            fails++;
            $display("FAIL conflict_pulse: werr=%b, required 0", werr0);
        end
    endtask

    task automatic test_overwrite();
        wdv = '0; wdv[1] = 16'h0022;
        step(1'b1, 5'b00010, wdv, 1'b0, 3'd0, 1'b0);
        wdv[1] = 16'h0033;
        step(1'b1, 5'b00010, wdv, 1'b0, 3'd0, 1'b0);
        tests++;
        if (ovf0 !== 2'b10 || valid0 !== 2'b10) begin
            fails++;
            $display("FAIL overwrite_ovf: ovf=%b valid=%b, required 10 10", ovf0, valid0);
        end
        wdv[1] = 16'h0044;
        step(1'b1, 5'b00010, wdv, 1'b1, 3'd1, 1'b0);
        tests++;
        if (rdd0 !== 8'h33 || rdv0 !== 1'b1 || valid0[1] !== 1'b1 || dout0[15:8] !== 8'h44 || ovf0 !== 2'b10) begin
            fails++;
            $display("FAIL write_consume: rdd=%h rdv=%b valid=%b d1=%h ovf=%b, required 33 1 1x 44 10",
                     rdd0, rdv0, valid0, dout0[15:8], ovf0);
        end
    endtask

    task automatic test_empty_read();
        wdv = '0;
        step(1'b1, 5'b00000, wdv, 1'b1, 3'd0, 1'b0);
        tests++;
        if (rdv0 !== 1'b0 || rdd0 !== 8'h33) begin
            fails++;
            $display("FAIL empty_read: rdv=%b rdd=%h, required 0 33", rdv0, rdd0);
        end
        step(1'b1, 5'b00000, wdv, 1'b1, 3'd6, 1'b0);
        tests++;
        if (rdv2 !== 1'b0 || rdd2 !== 16'h0033) begin
            fails++;
            $display("FAIL range_read: rdv=%b rdd=%h, required 0 0033", rdv2, rdd2);
        end
    endtask

    task automatic test_chan5();
        int pulses;
        wdv = '0;
        step(1'b0, 5'b00000, wdv, 1'b0, 3'd0, 1'b0);
        wdv[4] = 16'hBEEF;
        step(1'b1, 5'b10000, wdv, 1'b0, 3'd0, 1'b0);
        pulses = 0;
        for (int r = 0; r < 5; r++) begin
            step(1'b1, 5'b00000, wdv, 1'b1, 3'(r), 1'b0);
            if (rdv2) begin
                pulses++;
                tests++;
                if (r != 4 || rdd2 !== 16'hBEEF) begin
                    fails++;
                    $display("FAIL rotate_pulse: sel=%0d rdd=%h, required sel 4 beef", r, rdd2);
                end
            end
        end
        tests++;
        if (pulses != 1 || valid2 !== 5'b0) begin
            fails++;
            $display("FAIL rotate_count: pulses=%0d valid=%b, required 1 00000", pulses, valid2);
        end
        step(1'b1, 5'b10000, wdv, 1'b0, 3'd0, 1'b0);
        step(1'b0, 5'b00000, wdv, 1'b1, 3'd4, 1'b0);
        tests++;
        if (rdv2 !== 1'b0 || valid2 !== 5'b0 || rdd2 !== 16'h0 || dout2 !== 80'h0 ||
            ovf2 !== 5'b0 || werr2 !== 1'b0) begin
            fails++;
            $display("FAIL reset_on_read: rdv=%b valid=%b rdd=%h d4=%h, required all zero",
                     rdv2, valid2, rdd2, dout2[79:64]);
        end
        step(1'b1, 5'b00000, wdv, 1'b0, 3'd4, 1'b0);
        tests++;
        if (rdv2 !== 1'b0) begin
            fails++;
            $display("FAIL reset_no_pulse: rdv=%b, required 0", rdv2);
        end
    endtask

    task automatic test_random();
        logic [4:0] we;
        for (int n = 0; n < 400; n++) begin
            for (int j = 0; j < 5; j++) wdv[j] = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       we = '0;
                1:       we = 5'(1 << $urandom_range(0, 4));
                default: we = 5'($urandom);
            endcase
            step(($urandom_range(0, 31) != 0), we, wdv, 1'($urandom), 3'($urandom), 1'($urandom));
            for (int k = 0; k < 3; k++) begin
                tests++;
                if (a_valid[k] !== m_valid[k] || a_ovf[k] !== m_ovf[k] || a_werr[k] !== m_werr[k] ||
                    a_rdv[k] !== m_rdv[k] || a_rdd[k] !== m_rdd[k]) begin
                    fails++;
                    $display("FAIL rand_ctl inst%0d cyc%0d: valid=%b ovf=%b werr=%b rdv=%b rdd=%h, required %b %b %b %b %h",
                             k, n, a_valid[k], a_ovf[k], a_werr[k], a_rdv[k], a_rdd[k],
                             m_valid[k], m_ovf[k], m_werr[k], m_rdv[k], m_rdd[k]);
                end
                for (int j = 0; j < int'(NCH[k]); j++) begin
                    tests++;
                    if (a_dout[k][j] !== m_dout[k][j]) begin
                        fails++;
                        $display("FAIL rand_data inst%0d ch%0d cyc%0d: got %h, required %h",
                                 k, j, n, a_dout[k][j], m_dout[k][j]);
                    end
                end
`ifdef REG_BANK_PARITY_EN
                tests++;
                if (a_perr[k] !== m_perr[k]) begin
                    fails++;
                    $display("FAIL rand_par inst%0d cyc%0d: got %b, required %b", k, n, a_perr[k], m_perr[k]);
                end
`endif
            end
        end
    endtask

`ifdef REG_BANK_PARITY_EN
    task automatic test_parity();
        wdv = '0;
        step(1'b0, 5'b00000, wdv, 1'b0, 3'd0, 1'b0);
        wdv[0] = 16'h000F;
        step(1'b1, 5'b00001, wdv, 1'b0, 3'd0, 1'b1);
        step(1'b1, 5'b00000, wdv, 1'b1, 3'd0, 1'b0);
        tests++;
        if (perr0 !== 1'b1 || rdv0 !== 1'b1 || rdd0 !== 8'h0F) begin
            fails++;
            $display("FAIL parity_inject: perr=%b rdv=%b rdd=%h, required 1 1 0f", perr0, rdv0, rdd0);
        end
        step(1'b1, 5'b00001, wdv, 1'b0, 3'd0, 1'b0);
        step(1'b1, 5'b00000, wdv, 1'b1, 3'd0, 1'b0);
        tests++;
        if (perr0 !== 1'b0 || rdv0 !== 1'b1) begin
            fails++;
            $display("FAIL parity_clean: perr=%b rdv=%b, required 0 1", perr0, rdv0);
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_read();
        test_conflict();
        test_overwrite();
        test_empty_read();
        test_chan5();
`ifdef REG_BANK_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
